// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared types and defaults for the UART frame scheduler
// Purpose: state encodings, parameter defaults and the length type shared by
//          uart_frame_scheduler and uart_byte_issuer.
package uart_frame_pkg;

    localparam int         DEF_NUM_SRC      = 3;
    localparam int         DEF_MAX_LEN      = 420;
    localparam logic [7:0] DEF_SYNC_BYTE    = 8'hA5;
    localparam int         DEF_BUSY_TIMEOUT = 16;

    typedef logic [8:0] src_len_t;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GRANT,
        ST_SYNC,
        ST_ID,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_FETCH,
        ST_PAYLOAD,
        ST_CHK,
        ST_DONE
    } frame_state_e;

    typedef enum logic [1:0] {
        IS_IDLE,
        IS_WAIT_LOW,
        IS_WAIT_HIGH,
        IS_WAIT_DONE
    } issue_state_e;

    function automatic src_len_t clip_len(input src_len_t len, input src_len_t max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/uart_byte_issuer.sv
// rtl/uart_byte_issuer.sv - sends one byte to a busy/trigger style UART transmitter
// Purpose: accepts a byte on start_i, waits for the transmitter to go idle,
//          pulses tx_trigger_o for one cycle, waits for busy to rise (or a
//          timeout), then waits for busy to fall and pulses done_o.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   start_i,data_i  byte request (accepted only while idle)
//   tx_busy_i       transmitter busy
//   done_o          one-cycle pulse when the byte has been fully sent
//   tx_data_o       byte to transmitter, held from trigger to next trigger
//   tx_trigger_o    one-cycle start pulse to transmitter
module uart_byte_issuer
    import uart_frame_pkg::*;
#(
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       tx_busy_i,
    output logic       done_o,
    output logic [7:0] tx_data_o,
    output logic       tx_trigger_o
);

    localparam int            TW     = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BUSY_TIMEOUT - 1);

    issue_state_e  state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          trig_q, trig_d;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= IS_IDLE;
            timer_q   <= '0;
            data_q    <= '0;
            tx_data_q <= '0;
            trig_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            data_q    <= data_d;
            tx_data_q <= tx_data_d;
            trig_q    <= trig_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        data_d    = data_q;
        tx_data_d = tx_data_q;
        trig_d    = 1'b0;
        done_o    = 1'b0;
        case (state_q)
            IS_IDLE: begin
                if (start_i) begin
                    data_d  = data_i;
                    state_d = IS_WAIT_LOW;
                end
            end
            IS_WAIT_LOW: begin
                // Trigger is registered, so leaving this state guarantees a
                // single-cycle pulse and no back-to-back triggers.
                if (!tx_busy_i) begin
                    tx_data_d = data_q;
                    trig_d    = 1'b1;
                    timer_d   = '0;
                    state_d   = IS_WAIT_HIGH;
                end
            end
            IS_WAIT_HIGH: begin
                // timer_q counts cycles since the trigger became visible.
                if (tx_busy_i || (timer_q == T_LAST)) begin
                    state_d = IS_WAIT_DONE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            IS_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    done_o  = 1'b1;
                    state_d = IS_IDLE;
                end
            end
            default: state_d = IS_IDLE;
        endcase
    end

    assign tx_data_o    = tx_data_q;
    assign tx_trigger_o = trig_q;

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - round-robin framer of per-source byte streams onto one UART
// Purpose: latches per-source requests, grants them round-robin and sends
//          SYNC, id, length (2 bytes), payload and optional checksum.
// Option:  UART_FRAME_CHECKSUM_EN adds a mod-256 checksum byte (CHK state).
// Ports:
//   clk_in, rst_in           clock, synchronous active-low reset
//   enable_in                allows new grants
//   src_req_in, src_len_in   per-source request pulse and 9-bit length
//   src_grant_out            one-hot pulse when a frame starts
//   src_done_out             one-hot pulse after a frame's last byte
//   rd_sel_out, rd_addr_out  payload read port (data one cycle later)
//   rd_data_in               payload byte
//   tx_data_out, tx_trigger_out, tx_busy_in  transmitter interface
//   busy_out                 state is not IDLE
//   drop_count_out           saturating count of dropped requests
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int         NUM_SRC      = DEF_NUM_SRC,
    parameter int         MAX_LEN      = DEF_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE    = DEF_SYNC_BYTE,
    parameter int         BUSY_TIMEOUT = DEF_BUSY_TIMEOUT,
    localparam int        SEL_W        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 enable_in,
    input  logic [NUM_SRC-1:0]   src_req_in,
    input  logic [NUM_SRC*9-1:0] src_len_in,
    output logic [NUM_SRC-1:0]   src_grant_out,
    output logic [NUM_SRC-1:0]   src_done_out,
    output logic [SEL_W-1:0]     rd_sel_out,
    output logic [8:0]           rd_addr_out,
    input  logic [7:0]           rd_data_in,
    output logic [7:0]           tx_data_out,
    output logic                 tx_trigger_out,
    input  logic                 tx_busy_in,
    output logic                 busy_out,
    output logic [7:0]           drop_count_out
);

    localparam src_len_t MAX_LEN_L = src_len_t'(MAX_LEN);
`ifdef UART_FRAME_CHECKSUM_EN
    localparam frame_state_e ST_AFTER_DATA = ST_CHK;
`else
    localparam frame_state_e ST_AFTER_DATA = ST_DONE;
`endif

    frame_state_e       state_q, state_d;
    logic [NUM_SRC-1:0] pend_q, pend_d;
    logic [NUM_SRC-1:0] act_q, act_d;
    src_len_t           len_q [NUM_SRC];
    src_len_t           len_d [NUM_SRC];
    logic [SEL_W-1:0]   cur_q, cur_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;
    src_len_t           idx_q, idx_d;
    logic               issued_q, issued_d;
    logic [7:0]         drop_q, drop_d;
`ifdef UART_FRAME_CHECKSUM_EN
    logic [7:0]         chk_q, chk_d;
`endif

    logic               iss_start;
    logic [7:0]         iss_data;
    logic               iss_done;
    logic               is_send;
    src_len_t           cur_len;
    logic               win_found;
    logic [SEL_W-1:0]   win_sel;
    logic [SEL_W:0]     cand;

    uart_byte_issuer #(
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) u_issuer (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .start_i     (iss_start),
        .data_i      (iss_data),
        .tx_busy_i   (tx_busy_in),
        .done_o      (iss_done),
        .tx_data_o   (tx_data_out),
        .tx_trigger_o(tx_trigger_out)
    );

    // Round-robin search starting at ptr_q (last granted + 1).
    always_comb begin
        win_found = 1'b0;
        win_sel   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, ptr_q} + (SEL_W + 1)'(k);
            if (cand >= (SEL_W + 1)'(NUM_SRC)) begin
                cand = cand - (SEL_W + 1)'(NUM_SRC);
            end
            if (!win_found && pend_q[cand[SEL_W-1:0]]) begin
                win_found = 1'b1;
                win_sel   = cand[SEL_W-1:0];
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q  <= ST_IDLE;
            pend_q   <= '0;
            act_q    <= '0;
            cur_q    <= '0;
            ptr_q    <= '0;
            idx_q    <= '0;
            issued_q <= 1'b0;
            drop_q   <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                len_q[s] <= '0;
            end
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            act_q    <= act_d;
            cur_q    <= cur_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            issued_q <= issued_d;
            drop_q   <= drop_d;
            for (int s = 0; s < NUM_SRC; s++) begin
                len_q[s] <= len_d[s];
            end
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q    <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        act_d         = act_q;
        len_d         = len_q;
        cur_d         = cur_q;
        ptr_d         = ptr_q;
        idx_d         = idx_q;
        issued_d      = issued_q;
        drop_d        = drop_q;
`ifdef UART_FRAME_CHECKSUM_EN
        chk_d         = chk_q;
`endif
        iss_start     = 1'b0;
        iss_data      = '0;
        src_grant_out = '0;
        src_done_out  = '0;
        cur_len       = len_q[cur_q];

        case (state_q)
            ST_IDLE: begin
                if (enable_in && win_found) begin
                    cur_d   = win_sel;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                src_grant_out[cur_q] = 1'b1;
                pend_d[cur_q]        = 1'b0;
                act_d[cur_q]         = 1'b1;
                ptr_d    = (cur_q == SEL_W'(NUM_SRC - 1)) ? '0 : cur_q + 1'b1;
                idx_d    = '0;
                issued_d = 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
                chk_d    = '0;
`endif
                state_d  = ST_SYNC;
            end
            ST_SYNC: begin
                iss_data = SYNC_BYTE;
                if (iss_done) state_d = ST_ID;
            end
            ST_ID: begin
                iss_data = 8'(cur_q);
                if (iss_done) state_d = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                iss_data = {7'b0, cur_len[8]};
                if (iss_done) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                iss_data = cur_len[7:0];
                if (iss_done) begin
                    state_d = (cur_len == '0) ? ST_AFTER_DATA : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // rd_addr_out already shows idx_q; data is valid next cycle.
                state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                iss_data = rd_data_in;
                if (iss_done) begin
                    if (idx_q == cur_len - src_len_t'(1)) begin
                        state_d = ST_AFTER_DATA;
                    end else begin
                        idx_d   = idx_q + src_len_t'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHK: begin
                iss_data = chk_q;
                if (iss_done) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                src_done_out[cur_q] = 1'b1;
                act_d[cur_q]        = 1'b0;
                state_d             = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Each byte state issues exactly once, on its first cycle; the
        // issuer latches iss_data so rd_data_in may change afterwards.
        is_send = (state_q == ST_SYNC) || (state_q == ST_ID) ||
                  (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                  (state_q == ST_PAYLOAD);
`ifdef UART_FRAME_CHECKSUM_EN
        if (state_q == ST_CHK) is_send = 1'b1;
`endif
        if (is_send && !issued_q) begin
            iss_start = 1'b1;
            issued_d  = 1'b1;
`ifdef UART_FRAME_CHECKSUM_EN
            if (state_q != ST_SYNC && state_q != ST_CHK) begin
                chk_d = chk_q + iss_data;
            end
`endif
        end
        if (is_send && iss_done) begin
            issued_d = 1'b0;
        end

        // Requests are judged against registered pending/active state, so a
        // request for a different source during GRANT is never lost.
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_req_in[s]) begin
                if (pend_q[s] || act_q[s]) begin
                    if (drop_d != 8'hFF) drop_d = drop_d + 8'd1;
                end else begin
                    pend_d[s] = 1'b1;
                    len_d[s]  = clip_len(src_len_in[s*9 +: 9], MAX_LEN_L);
                end
            end
        end
    end

    assign rd_sel_out     = cur_q;
    assign rd_addr_out    = idx_q;
    assign busy_out       = (state_q != ST_IDLE);
    assign drop_count_out = drop_q;

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - scoreboard bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

    localparam int BT = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        enable_in;
    logic [2:0]  src_req_in;
    logic [26:0] src_len_in;
    logic [2:0]  src_grant_out;
    logic [2:0]  src_done_out;
    logic [1:0]  rd_sel_out;
    logic [8:0]  rd_addr_out;
    logic [7:0]  rd_data_in;
    logic [7:0]  tx_data_out;
    logic        tx_trigger_out;
    logic        tx_busy_in;
    logic        busy_out;
    logic [7:0]  drop_count_out;

    always #5 clk_in = ~clk_in;

    uart_frame_scheduler #(
        .NUM_SRC(3), .MAX_LEN(420), .SYNC_BYTE(8'hA5), .BUSY_TIMEOUT(BT)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
        .src_req_in(src_req_in), .src_len_in(src_len_in),
        .src_grant_out(src_grant_out), .src_done_out(src_done_out),
        .rd_sel_out(rd_sel_out), .rd_addr_out(rd_addr_out), .rd_data_in(rd_data_in),
        .tx_data_out(tx_data_out), .tx_trigger_out(tx_trigger_out), .tx_busy_in(tx_busy_in),
        .busy_out(busy_out), .drop_count_out(drop_count_out)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [8:0] exp_bytes[$];
    int         exp_grant[$];
    int         exp_done[$];
    int         cyc = 0;
    int         n_trig = 0;
    int         last_trig_cyc = -1;
    int         busy_cnt = 0;
    logic       timeout_mode = 1'b0;
    logic       prev_trig = 1'b0;
    logic [1:0] sel_prev = '0;
    logic [8:0] addr_prev = '0;
    logic [8:0] mon_exp;
    int         mon_id;
    int         gap;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pay(input int s, input int a);
        int v;
        v = (s == 1) ? (a + 1) * 10 : s * 50 + a * 3 + 1;
        return v[7:0];
    endfunction

    task automatic push_frame(input int s, input int len);
        int         l;
        logic [8:0] lv;
        logic [7:0] sum;
        l  = (len > 420) ? 420 : len;
        lv = l[8:0];
        exp_grant.push_back(s);
        exp_bytes.push_back(9'h0A5);
        exp_bytes.push_back(9'(s));
        exp_bytes.push_back({8'h00, lv[8]});
        exp_bytes.push_back({1'b0, lv[7:0]});
        sum = 8'(s) + {7'b0, lv[8]} + lv[7:0];
        for (int i = 0; i < l; i++) begin
            exp_bytes.push_back({1'b0, pay(s, i)});
            sum = sum + pay(s, i);
        end
`ifdef UART_FRAME_CHECKSUM_EN
        exp_bytes.push_back({1'b0, sum});
`endif
        exp_done.push_back(s);
    endtask

    // Transmitter, payload memory and output scoreboard, all on the falling edge.
    always @(negedge clk_in) begin
        cyc++;
        if (rst_in) begin
            if (tx_trigger_out) begin
                check_eq("no_double_trig", 32'(prev_trig), 32'd0);
                if (exp_bytes.size() > 0) mon_exp = exp_bytes.pop_front();
                else mon_exp = 9'h1FF;
                check_eq("tx_byte", 32'(tx_data_out), 32'(mon_exp));
                if (timeout_mode && last_trig_cyc >= 0) begin
                    gap = cyc - last_trig_cyc;
                    check_eq("timeout_gap", 32'(gap >= BT && gap <= BT + 4), 32'd1);
                end
                n_trig++;
                last_trig_cyc = cyc;
            end
            if (src_grant_out != 3'b000) begin
                mon_id = (exp_grant.size() > 0) ? exp_grant.pop_front() : 7;
                check_eq("grant", 32'(src_grant_out), 32'd1 << mon_id);
            end
            if (src_done_out != 3'b000) begin
                mon_id = (exp_done.size() > 0) ? exp_done.pop_front() : 7;
                check_eq("done", 32'(src_done_out), 32'd1 << mon_id);
            end
        end
        prev_trig = tx_trigger_out;
        if (busy_cnt > 0) busy_cnt--;
        if (tx_trigger_out && !timeout_mode) busy_cnt = 4;
        tx_busy_in = (busy_cnt > 0);
        rd_data_in = pay(int'(sel_prev), int'(addr_prev));
        sel_prev   = rd_sel_out;
        addr_prev  = rd_addr_out;
    end

    task automatic drive_req(input logic [2:0] mask, input int l0, input int l1, input int l2);
        @(posedge clk_in); #1;
        src_req_in = mask;
        src_len_in = {l2[8:0], l1[8:0], l0[8:0]};
        @(posedge clk_in); #1;
        src_req_in = '0;
    endtask

    task automatic req(input int s, input int len);
        logic [2:0] m;
        m = 3'b001 << s;
        drive_req(m, len, len, len);
    endtask

    task automatic do_reset();
        rst_in = 1'b0;
        busy_cnt = 0;
        repeat (2) @(posedge clk_in);
        #1;
        exp_bytes.delete();
        exp_grant.delete();
        exp_done.delete();
        rst_in = 1'b1;
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_bytes.size() != 0 || exp_done.size() != 0 || busy_out) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        check_eq({tag, "_left"}, 32'(exp_bytes.size()), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy_out), 32'd0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_busy"}, 32'(busy_out), 32'd0);
        check_eq({tag, "_trig"}, 32'(tx_trigger_out), 32'd0);
        check_eq({tag, "_txd"}, 32'(tx_data_out), 32'd0);
        check_eq({tag, "_grant"}, 32'(src_grant_out), 32'd0);
        check_eq({tag, "_done"}, 32'(src_done_out), 32'd0);
        check_eq({tag, "_drop"}, 32'(drop_count_out), 32'd0);
        check_eq({tag, "_addr"}, 32'(rd_addr_out), 32'd0);
        check_eq({tag, "_sel"}, 32'(rd_sel_out), 32'd0);
    endtask

    initial begin
        int n;
        int base;
        rst_in = 1'b0; enable_in = 1'b1; src_req_in = '0; src_len_in = '0;
        tx_busy_in = 1'b0; rd_data_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        check_zero("reset");
        rst_in = 1'b1;

        // Single frame from source 1
        push_frame(1, 3);
        req(1, 3);
        drain("single", 2000);

        // Round-robin 0,2 then 0 again
        do_reset();
        push_frame(0, 2); push_frame(2, 1); push_frame(0, 3);
        drive_req(3'b101, 2, 0, 1);
        n = 0;
        while (!src_done_out[0] && n < 2000) begin @(negedge clk_in); n++; end
        check_eq("rr_src0_done", 32'(src_done_out[0]), 32'd1);
        req(0, 3);
        drain("rr", 3000);

        // Overrun while active, then while pending (enable low)
        do_reset();
        push_frame(0, 5);
        req(0, 5);
        repeat (10) @(negedge clk_in);
        req(0, 7);
        drain("ovr", 3000);
        check_eq("drop_active", 32'(drop_count_out), 32'd1);
        enable_in = 1'b0;
        req(1, 2);
        req(1, 9);
        repeat (5) @(negedge clk_in);
        check_eq("dis_idle", 32'(busy_out), 32'd0);
        check_eq("drop_pending", 32'(drop_count_out), 32'd2);
        push_frame(1, 2);
        enable_in = 1'b1;
        drain("ovr_len", 2000);

        // Length edge cases: 0 and clipped 500
        do_reset();
        push_frame(0, 0); push_frame(2, 500);
        drive_req(3'b101, 0, 0, 500);
        drain("len", 9000);

        // Busy timeout with transmitter never raising busy
        do_reset();
        timeout_mode = 1'b1;
        last_trig_cyc = -1;
        push_frame(1, 2);
        req(1, 2);
        drain("tmo", 1000);
        timeout_mode = 1'b0;

        // Reset during payload byte 2
        do_reset();
        push_frame(1, 5);
        base = n_trig;
        req(1, 5);
        n = 0;
        while (n_trig < base + 6 && n < 2000) begin @(negedge clk_in); n++; end
        check_eq("reach_pay2", 32'(n_trig - base), 32'd6);
        rst_in = 1'b0; busy_cnt = 0;
        @(posedge clk_in); #1;
        check_zero("midrst");
        exp_bytes.delete(); exp_grant.delete(); exp_done.delete();
        rst_in = 1'b1;
        push_frame(2, 1);
        req(2, 1);
        drain("post_rst", 2000);

        // Enable falls mid-frame: frame completes, pending source 1 waits
        do_reset();
        push_frame(0, 3);
        drive_req(3'b011, 3, 2, 0);
        repeat (12) @(negedge clk_in);
        enable_in = 1'b0;
        drain("en_fall", 2000);
        repeat (40) @(negedge clk_in);
        check_eq("en_hold_idle", 32'(busy_out), 32'd0);
        push_frame(1, 2);
        enable_in = 1'b1;
        drain("en_resume", 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

endmodule
